// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: state encoding, iteration
// count and divide opcode values.
package div_unit_pkg;

  // One restoring step per quotient bit.
  localparam int unsigned IterCount = 32;
  localparam int unsigned CntWidth  = 6;

  typedef enum logic [1:0] {
    DivIdle,
    DivBusy,
    DivDone
  } div_state_e;

  // Value of signed_op selecting each instruction.
  localparam logic OpDivu = 1'b0;
  localparam logic OpDiv  = 1'b1;

  // Two's-complement negate when en is set, pass-through otherwise.
  function automatic logic [31:0] cond_neg(input logic en, input logic [31:0] v);
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
// quo_i carries the not-yet-consumed dividend bits in its upper part and the
// quotient bits produced so far in its lower part.
module div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] shifted;

  // Shift the next dividend bit into the partial remainder, subtract if it fits.
  always_comb begin
    shifted = {rem_i, quo_i[31]};
    if (shifted >= {1'b0, divisor_i}) begin
      // Result is below divisor_i, so 32-bit wrap-around arithmetic is exact.
      rem_o = shifted[31:0] - divisor_i;
      quo_o = {quo_i[30:0], 1'b1};
    end else begin
      rem_o = shifted[31:0];
      quo_o = {quo_i[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: 32 restoring iterations on operand magnitudes,
// sign fix-up on the way out, one-cycle ready pulse that acts as the HI/LO
// write enable.
// Optional feature: define DIV_ZERO_FAST_EN to skip the iterations when the
// divisor is zero (IDLE goes straight to DONE).
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        annul,
  output logic        stall_req,
  output logic        ready,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CntWidth-1:0] LastIter = CntWidth'(IterCount - 1);

  div_state_e state_q, state_d;

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] a_q, a_d;
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;
  logic        zero_q, zero_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        capture;
  logic        last_step;
  logic        b_zero;
  logic        fast_zero;
  logic        is_signed;
  logic [31:0] step_rem;
  logic [31:0] step_quo;

  assign is_signed = (signed_op == OpDiv);
  assign b_zero    = (op_b == 32'd0);
  assign capture   = (state_q == DivIdle) && start && !annul;
  assign last_step = (state_q == DivBusy) && (cnt_q == LastIter);

`ifdef DIV_ZERO_FAST_EN
  assign fast_zero = b_zero;
`else
  assign fast_zero = 1'b0;
`endif

  div_step u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DivIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; annul overrides everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DivIdle: begin
        if (start) begin
          state_d = fast_zero ? DivDone : DivBusy;
        end
      end
      DivBusy: begin
        if (last_step) begin
          state_d = DivDone;
        end
      end
      DivDone: state_d = DivIdle;
      default: state_d = DivIdle;
    endcase
    if (annul) begin
      state_d = DivIdle;
    end
  end

  // FSM outputs; both forced low while reset is asserted.
  always_comb begin
    stall_req = rst && (((state_q == DivIdle) && start) || (state_q == DivBusy));
    ready     = rst && (state_q == DivDone);
  end

  // Operand capture with sign stripping, then one iteration per BUSY cycle.
  always_comb begin
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    a_d     = a_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    zero_d  = zero_q;
    if (capture) begin
      cnt_d   = '0;
      rem_d   = '0;
      quo_d   = cond_neg(is_signed && op_a[31], op_a);
      dvs_d   = cond_neg(is_signed && op_b[31], op_b);
      a_d     = op_a;
      neg_q_d = is_signed && (op_a[31] ^ op_b[31]);
      neg_r_d = is_signed && op_a[31];
      zero_d  = b_zero;
    end else if (state_q == DivBusy) begin
      cnt_d = cnt_q + {{(CntWidth-1){1'b0}}, 1'b1};
      rem_d = step_rem;
      quo_d = step_quo;
    end
  end

  // Result values, loaded only on the edge that enters DONE.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (capture && fast_zero) begin
      lo_d = '1;
      hi_d = op_a;
    end else if (last_step && !annul) begin
      if (zero_q) begin
        lo_d = '1;
        hi_d = a_q;
      end else begin
        // Most-negative / -1 naturally yields 0x80000000 after negation.
        lo_d = cond_neg(neg_q_q, step_quo);
        hi_d = cond_neg(neg_r_q, step_rem);
      end
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      zero_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      a_q     <= a_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      zero_q  <= zero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: cycle-level reference model plus
// directed vectors with literal expectations.
module tb_div_unit;

`ifdef DIV_ZERO_FAST_EN
  localparam bit FastZero = 1'b1;
`else
  localparam bit FastZero = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        stall_req;
  logic        ready;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .annul     (annul),
    .stall_req (stall_req),
    .ready     (ready),
    .hi        (hi),
    .lo        (lo)
  );

  // Architectural result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Reference model: remaining busy cycles, pending result, done flag.
  int          m_cnt = 0;
  bit          m_ready = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] p_hi = '0;
  logic [31:0] p_lo = '0;

  always @(posedge clk) begin
    if (!rst) begin
      m_cnt   <= 0;
      m_ready <= 1'b0;
      m_hi    <= '0;
      m_lo    <= '0;
    end else if (annul) begin
      m_cnt   <= 0;
      m_ready <= 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_ready <= 1'b1;
        m_hi    <= p_hi;
        m_lo    <= p_lo;
      end
    end else if (m_ready) begin
      m_ready <= 1'b0;
    end else if (start) begin
      {p_hi, p_lo} <= ref_div(signed_op, op_a, op_b);
      if (FastZero && op_b == 32'd0) begin
        m_ready      <= 1'b1;
        {m_hi, m_lo} <= ref_div(signed_op, op_a, op_b);
      end else begin
        m_cnt <= 32;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the clock edge.
  always @(negedge clk) begin
    logic exp_ready;
    logic exp_stall;
    exp_ready = rst && m_ready;
    exp_stall = rst && ((m_cnt > 0) || (!m_ready && start));
    tests++;
    if (ready !== exp_ready) begin
      fails++;
      $display("FAIL model_ready at %0t: got %b want %b", $time, ready, exp_ready);
    end
    tests++;
    if (stall_req !== exp_stall) begin
      fails++;
      $display("FAIL model_stall at %0t: got %b want %b", $time, stall_req, exp_stall);
    end
    if (exp_ready) begin
      tests++;
      if (lo !== m_lo || hi !== m_hi) begin
        fails++;
        $display("FAIL model_result at %0t: got hi=%h lo=%h want hi=%h lo=%h",
                 $time, hi, lo, m_hi, m_lo);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Issue one divide, measure latency and stall length, check literal results.
  task automatic do_div(input string name, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_lo,
                        input logic [31:0] exp_hi, input int exp_lat);
    int k;
    int st;
    k  = -1;
    st = 0;
    @(posedge clk); #1;
    start = 1'b1; signed_op = s; op_a = a; op_b = b;
    @(negedge clk);
    if (stall_req === 1'b1) st++;
    @(posedge clk); #1;
    start = 1'b0; op_a = ~a; op_b = 32'd5; signed_op = ~s;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (stall_req === 1'b1) st++;
      if (ready === 1'b1) begin
        k = i;
        break;
      end
    end
    chk({name, " latency"}, k, exp_lat);
    chk({name, " stall"}, st, exp_lat);
    chk({name, " lo"}, lo, exp_lo);
    chk({name, " hi"}, hi, exp_hi);
  endtask

  initial begin
    int k;
    int pulses;
    logic [31:0] got_lo;
    logic [31:0] got_hi;

    // Reset with start held: stall must stay low, outputs cleared.
    rst = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", ready, 0);
    chk("reset stall", stall_req, 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    @(posedge clk); #1;
    start = 1'b0;
    rst = 1'b1;

    do_div("u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    do_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    do_div("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
    do_div("s_min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
    do_div("u_max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);
    do_div("u_big", 1'b0, 32'h1234_5678, 32'h0000_1000, 32'h0001_2345, 32'h0000_0678, 33);
    do_div("u5/9", 1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 33);
    do_div("u_div0", 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234,
           FastZero ? 1 : 33);
    do_div("s_div0", 1'b1, 32'h8000_1234, 32'd0, 32'hFFFF_FFFF, 32'h8000_1234,
           FastZero ? 1 : 33);

    // Annul in the 10th busy cycle, then a fresh divide the next cycle.
    @(posedge clk); #1;
    start = 1'b1; signed_op = 1'b0; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    start = 1'b1; op_a = 32'd50; op_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    k = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        k = i;
        break;
      end
    end
    chk("annul latency", k, 33);
    chk("annul lo", lo, 32'd10);
    chk("annul hi", hi, 32'd0);

    // Reset in the 20th busy cycle while start is held high.
    @(posedge clk); #1;
    start = 1'b1; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #1;
    repeat (19) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("midreset ready", ready, 0);
    chk("midreset stall", stall_req, 0);
    chk("midreset hi", hi, 0);
    chk("midreset lo", lo, 0);
    repeat (40) @(negedge clk);

    // Start held through most of BUSY yields exactly one result.
    @(posedge clk); #1;
    start = 1'b1; signed_op = 1'b0; op_a = 32'd200; op_b = 32'd9;
    repeat (25) @(posedge clk);
    #1 start = 1'b0;
    pulses = 0;
    got_lo = '0;
    got_hi = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        pulses++;
        got_lo = lo;
        got_hi = hi;
      end
    end
    chk("held_start pulses", pulses, 1);
    chk("held_start lo", got_lo, 32'd22);
    chk("held_start hi", got_hi, 32'd2);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have rst  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 SHALL have start  input  1  request a divide; sampled only in IDLE.
REQ-004 SHALL have signed_op  input  1  1 = DIV (signed), 0 = DIVU (unsigned); captured with start.
REQ-005 SHALL have op_a  input  32  dividend; captured with start.
REQ-006 SHALL have op_b  input  32  divisor; captured with start.
REQ-007 SHALL have annul  input  1  pipeline flush; aborts any operation in progress.
REQ-008 SHALL have stall_req  output  1  hold IF/ID/EX while a divide is outstanding.
REQ-009 SHALL have ready  output  1  one-cycle pulse marking valid hi/lo.
REQ-010 SHALL have hi  output  32  remainder; lo  output  32  quotient.

Function
REQ-011 SHALL implement states IDLE, BUSY, DONE.
REQ-012 IDLE: start=1 and annul=0 SHALL capture the operands, clear the iteration counter, and go to BUSY.
REQ-013 BUSY SHALL perform one restoring shift-subtract step per cycle on the operand magnitudes, for exactly 32 cycles, using a 6-bit counter.
REQ-014 After the 32nd step the block SHALL go to DONE; DONE SHALL last one cycle with ready=1, then return to IDLE.
REQ-015 Latency: ready SHALL be high exactly 33 cycles after the edge that sampled start.
REQ-016 stall_req SHALL be asserted combinationally while start=1 in IDLE, and in every BUSY cycle; it SHALL be 0 in DONE and in idle IDLE.
REQ-017 Signed: quotient SHALL be negated when operand signs differ; remainder sign SHALL equal the dividend sign.
REQ-018 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0 (no trap).
REQ-019 Divisor 0: the result SHALL be lo=0xFFFFFFFF and hi=op_a, for both signed and unsigned.
REQ-020 hi/lo SHALL hold their last values outside DONE; they are meaningful only while ready=1.
REQ-021 start during BUSY or DONE SHALL be ignored; it is not queued.
REQ-022 annul=1 in any state SHALL force IDLE on the next edge, with no ready pulse, and SHALL take priority over start.
REQ-023 The hi/lo result SHALL be written to the HI/LO write path (we_hi/we_lo) only via ready.

Reset
REQ-024 rst=0 SHALL set state=IDLE, counter=0, ready=0, hi=0, lo=0 and the operand registers to 0; stall_req SHALL be 0 during reset.
REQ-025 rst=0 in mid-BUSY SHALL abandon the operation; no ready pulse follows.

Configuration
REQ-026 Macro DIV_ZERO_FAST_EN defined: divisor 0 SHALL skip BUSY, so IDLE goes to DONE and ready is high 1 cycle after start is sampled.
REQ-027 Macro absent: divisor 0 SHALL run the full 32 BUSY cycles; the result values are as in REQ-019 either way.

Structure
REQ-028 State encodings (DivIdle/DivBusy/DivDone), the iteration count 32, and the divide opcode constants SHALL live in the shared define file.
REQ-029 One combinational sub-module, div_step, SHALL implement a single restoring iteration: partial remainder and quotient in, updated pair out. div_unit SHALL contain the FSM, the sign pre/post-processing, and the registers.

Verification
REQ-030 Unsigned 100 / 7, start pulsed once -> ready 33 cycles later; lo=14, hi=2; stall_req high for 33 cycles.
REQ-031 Signed -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); signed 7 / -2 -> lo=-3, hi=1.
REQ-032 Signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; unsigned 0xFFFFFFFF / 1 -> lo=0xFFFFFFFF, hi=0.
REQ-033 Divisor 0 with op_a=0x1234 -> lo=0xFFFFFFFF, hi=0x1234; ready at cycle 1 with DIV_ZERO_FAST_EN, at cycle 33 without.
REQ-034 annul at BUSY cycle 10, then start 50 / 5 the next cycle -> no stale ready; ready 33 cycles after the new start with lo=10, hi=0.
REQ-035 rst=0 at BUSY cycle 20 -> next cycle ready=0, stall_req=0, hi=lo=0; a start held high during BUSY produces only one result.
